// File: rtl/alu_pkg.sv
// Shared definitions for the ALU self-test slice.
// Opcodes, response packing and controller states.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    // Bit positions of a packed response {s, c, zero, of}
    localparam int RESP_OF   = 0;
    localparam int RESP_ZERO = 1;
    localparam int RESP_C    = 2;
    localparam int RESP_S    = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } st_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_selftest_ref_model.sv
// Reference ALU: maps (op, x, y) to the expected result and flags.
// Purely combinational; also reused by the bench.
module alu_ref_model
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             c,
    output logic             zero,
    output logic             of
);

    logic [WIDTH:0] sum;
    logic           lt;

    assign lt = $signed(x) < $signed(y);

    // Expected response for the current stimulus
    always_comb begin
        sum = '0;
        s   = '0;
        c   = 1'b0;
        of  = 1'b0;
        unique case (op)
            OP_ADD: begin
                sum = {1'b0, x} + {1'b0, y};
                s   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                of  = (x[WIDTH-1] == y[WIDTH-1]) &&
                      (s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
                s   = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                of  = (x[WIDTH-1] != y[WIDTH-1]) &&
                      (s[WIDTH-1] != x[WIDTH-1]);
            end
            OP_NOT: s = ~x;
            OP_AND: s = x & y;
            OP_OR:  s = x | y;
            OP_XOR: s = x ^ y;
            OP_SLT: s = {{(WIDTH-1){1'b0}}, lt};
            OP_EQ:  s = {{(WIDTH-1){1'b0}}, x == y};
            default: s = '0;
        endcase
        zero = (s == '0);
    end

endmodule

// File: rtl/alu_selftest.sv
// On-chip exhaustive sweep of the ALU against a reference model.
// Counts mismatches and captures the first failing vector.
module alu_selftest
    import alu_pkg::*;
#(
    parameter int         WIDTH   = 4,
    parameter logic [7:0] OP_MASK = 8'hFF,
    parameter int         SETTLE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [2:0]       op,
    output logic             in_c,
    output logic [WIDTH-1:0] in_x,
    output logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] out_s,
    input  logic             out_c,
    input  logic             zero,
    input  logic             overflow,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [15:0]      vec_count,
    output logic [2:0]       fail_op,
    output logic [WIDTH-1:0] fail_x,
    output logic [WIDTH-1:0] fail_y,
    output logic [WIDTH+2:0] fail_got
);

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    st_t              state;
    st_t              state_nxt;
    logic [2:0]       iop;
    logic [WIDTH-1:0] ix;
    logic [WIDTH-1:0] iy;
    logic [WW-1:0]    wait_cnt;
    logic             wait_done;
    logic [2:0]       first_op;
    logic             has_first;
    logic [2:0]       next_op;
    logic             has_next;
    logic             last_vec;
    logic [WIDTH-1:0] exp_s;
    logic             exp_c;
    logic             exp_z;
    logic             exp_of;
    logic [WIDTH+2:0] got;
    logic [WIDTH+2:0] expd;
    logic             mismatch;

    assign in_c      = 1'b0;
    assign wait_done = (wait_cnt == WW'(SETTLE - 1));
    assign last_vec  = (&iy) && (&ix) && !has_next;

    alu_ref_model #(.WIDTH(WIDTH)) u_model (
        .op   (op),
        .x    (in_x),
        .y    (in_y),
        .s    (exp_s),
        .c    (exp_c),
        .zero (exp_z),
        .of   (exp_of)
    );

    // Pack observed and expected responses in fail_got order
    always_comb begin
        got                     = '0;
        got[RESP_S +: WIDTH]    = out_s;
        got[RESP_C]             = out_c;
        got[RESP_ZERO]          = zero;
        got[RESP_OF]            = overflow;
        expd                    = '0;
        expd[RESP_S +: WIDTH]   = exp_s;
        expd[RESP_C]            = exp_c;
        expd[RESP_ZERO]         = exp_z;
        expd[RESP_OF]           = exp_of;
        mismatch                = (got != expd);
    end

    // Lowest enabled opcode, and lowest enabled opcode above the current one
    always_comb begin
        has_first = 1'b0;
        first_op  = 3'd0;
        has_next  = 1'b0;
        next_op   = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (OP_MASK[k]) begin
                has_first = 1'b1;
                first_op  = 3'(k);
                if (k > int'(iop)) begin
                    has_next = 1'b1;
                    next_op  = 3'(k);
                end
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = has_first ? ST_DRIVE : ST_DONE;
            end
            ST_DRIVE: state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_done) state_nxt = ST_CHECK;
            ST_CHECK: state_nxt = last_vec ? ST_DONE : ST_DRIVE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        busy = (state == ST_DRIVE) || (state == ST_WAIT) ||
               (state == ST_CHECK);
        done = (state == ST_DONE);
        pass = done && (err_count == 16'd0);
    end

    // Stimulus indices, ALU input registers, counters and fail capture
    always_ff @(posedge clk) begin
        if (rst) begin
            iop       <= '0;
            ix        <= '0;
            iy        <= '0;
            wait_cnt  <= '0;
            op        <= '0;
            in_x      <= '0;
            in_y      <= '0;
            err_count <= '0;
            vec_count <= '0;
            fail_op   <= '0;
            fail_x    <= '0;
            fail_y    <= '0;
            fail_got  <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        iop       <= first_op;
                        ix        <= '0;
                        iy        <= '0;
                        err_count <= '0;
                        vec_count <= '0;
                        fail_op   <= '0;
                        fail_x    <= '0;
                        fail_y    <= '0;
                        fail_got  <= '0;
                    end
                end
                ST_DRIVE: begin
                    op       <= iop;
                    in_x     <= ix;
                    in_y     <= iy;
                    wait_cnt <= '0;
                end
                ST_WAIT: wait_cnt <= wait_cnt + WW'(1);
                ST_CHECK: begin
                    vec_count <= sat_inc(vec_count);
                    if (mismatch) begin
                        err_count <= sat_inc(err_count);
                        if (err_count == 16'd0) begin
                            fail_op  <= op;
                            fail_x   <= in_x;
                            fail_y   <= in_y;
                            fail_got <= got;
                        end
                    end
                    iy <= iy + WIDTH'(1);
                    if (&iy) begin
                        ix <= ix + WIDTH'(1);
                        if (&ix) iop <= next_op;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: reference-model vector table plus full
// sweeps against a behavioural ALU with optional stuck-flag faults.
module tb_alu_selftest;

    localparam int LIMIT = 10000;

    logic clk;
    logic rst;
    logic [1:0] fault;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Independent behavioural ALU, WIDTH=4: {s, c, zero, of}
    function automatic logic [6:0] alu_beh(input logic [2:0] o,
                                           input logic [3:0] x,
                                           input logic [3:0] y);
        int ux, uy, sx, sy, r, sr;
        logic [3:0] s;
        logic c, of;
        ux = int'(x);
        uy = int'(y);
        sx = (ux > 7) ? ux - 16 : ux;
        sy = (uy > 7) ? uy - 16 : uy;
        s = 4'd0; c = 1'b0; of = 1'b0;
        case (o)
            3'd0: begin
                r = ux + uy; s = 4'(r); c = (r > 15);
                sr = sx + sy; of = (sr > 7) || (sr < -8);
            end
            3'd1: begin
                r = ux + (15 - uy) + 1; s = 4'(r); c = (r > 15);
                sr = sx - sy; of = (sr > 7) || (sr < -8);
            end
            3'd2: s = ~x;
            3'd3: s = x & y;
            3'd4: s = x | y;
            3'd5: s = x ^ y;
            3'd6: s = (sx < sy) ? 4'd1 : 4'd0;
            default: s = (ux == uy) ? 4'd1 : 4'd0;
        endcase
        return {s, c, (s == 4'd0), of};
    endfunction

    // DUT A: OP_MASK 03, ALU with injectable faults
    logic start_a, c_a, co_a, z_a, of_a, busy_a, done_a, pass_a;
    logic [2:0] op_a, fop_a;
    logic [3:0] x_a, y_a, s_a, fx_a, fy_a;
    logic [6:0] fgot_a, resp_a;
    logic [15:0] err_a, vec_a;

    assign resp_a = alu_beh(op_a, x_a, y_a);
    assign s_a    = resp_a[6:3];
    assign co_a   = (fault == 2'd1) ? 1'b0 : resp_a[2];
    assign z_a    = (fault == 2'd2) ? 1'b0 : resp_a[1];
    assign of_a   = resp_a[0];

    alu_selftest #(.WIDTH(4), .OP_MASK(8'h03), .SETTLE(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .op(op_a), .in_c(c_a), .in_x(x_a), .in_y(y_a),
        .out_s(s_a), .out_c(co_a), .zero(z_a), .overflow(of_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .vec_count(vec_a),
        .fail_op(fop_a), .fail_x(fx_a), .fail_y(fy_a),
        .fail_got(fgot_a)
    );

    // DUT B: OP_MASK E4 (skips opcodes), healthy ALU
    logic start_b, c_b, busy_b, done_b, pass_b;
    logic [2:0] op_b, fop_b;
    logic [3:0] x_b, y_b, fx_b, fy_b;
    logic [6:0] fgot_b, resp_b;
    logic [15:0] err_b, vec_b;

    assign resp_b = alu_beh(op_b, x_b, y_b);

    alu_selftest #(.WIDTH(4), .OP_MASK(8'hE4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .op(op_b), .in_c(c_b), .in_x(x_b), .in_y(y_b),
        .out_s(resp_b[6:3]), .out_c(resp_b[2]),
        .zero(resp_b[1]), .overflow(resp_b[0]),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .vec_count(vec_b),
        .fail_op(fop_b), .fail_x(fx_b), .fail_y(fy_b),
        .fail_got(fgot_b)
    );

    // DUT N: no opcodes enabled
    logic start_n, c_n, busy_n, done_n, pass_n;
    logic [2:0] op_n, fop_n;
    logic [3:0] x_n, y_n, fx_n, fy_n;
    logic [6:0] fgot_n;
    logic [15:0] err_n, vec_n;

    alu_selftest #(.WIDTH(4), .OP_MASK(8'h00), .SETTLE(1)) dut_n (
        .clk(clk), .rst(rst), .start(start_n),
        .op(op_n), .in_c(c_n), .in_x(x_n), .in_y(y_n),
        .out_s(4'd0), .out_c(1'b0), .zero(1'b1), .overflow(1'b0),
        .busy(busy_n), .done(done_n), .pass(pass_n),
        .err_count(err_n), .vec_count(vec_n),
        .fail_op(fop_n), .fail_x(fx_n), .fail_y(fy_n),
        .fail_got(fgot_n)
    );

    // Standalone reference model for table checks
    logic [2:0] t_op;
    logic [3:0] t_x, t_y, t_s;
    logic t_c, t_z, t_of;

    alu_ref_model #(.WIDTH(4)) u_ref (
        .op(t_op), .x(t_x), .y(t_y),
        .s(t_s), .c(t_c), .zero(t_z), .of(t_of)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] x;
        logic [3:0] y;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[18];

    task automatic sweep_a(input int poke, output int cyc);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("busy_rise", 64'(busy_a), 64'd1);
        cyc = 0;
        while (!done_a && cyc < LIMIT) begin
            start_a = (cyc == poke);
            @(negedge clk);
            cyc++;
        end
        start_a = 1'b0;
        check("busy_fall", 64'(busy_a), 64'd0);
    endtask

    int cyc;

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        fault   = 2'd0;
        start_a = 1'b0;
        start_b = 1'b0;
        start_n = 1'b0;
        t_op = 3'd0; t_x = 4'd0; t_y = 4'd0;

        tbl[0]  = '{3'd0, 4'h3, 4'h4, 7'b0111_0_0_0};
        tbl[1]  = '{3'd0, 4'h7, 4'h1, 7'b1000_0_0_1};
        tbl[2]  = '{3'd0, 4'hF, 4'h1, 7'b0000_1_1_0};
        tbl[3]  = '{3'd0, 4'h8, 4'h8, 7'b0000_1_1_1};
        tbl[4]  = '{3'd1, 4'h5, 4'h3, 7'b0010_1_0_0};
        tbl[5]  = '{3'd1, 4'h3, 4'h5, 7'b1110_0_0_0};
        tbl[6]  = '{3'd1, 4'h8, 4'h1, 7'b0111_1_0_1};
        tbl[7]  = '{3'd1, 4'h7, 4'h7, 7'b0000_1_1_0};
        tbl[8]  = '{3'd1, 4'h0, 4'h1, 7'b1111_0_0_0};
        tbl[9]  = '{3'd2, 4'h5, 4'h0, 7'b1010_0_0_0};
        tbl[10] = '{3'd2, 4'hF, 4'h3, 7'b0000_0_1_0};
        tbl[11] = '{3'd3, 4'hC, 4'hA, 7'b1000_0_0_0};
        tbl[12] = '{3'd4, 4'hC, 4'h3, 7'b1111_0_0_0};
        tbl[13] = '{3'd5, 4'hA, 4'hA, 7'b0000_0_1_0};
        tbl[14] = '{3'd6, 4'h8, 4'h1, 7'b0001_0_0_0};
        tbl[15] = '{3'd6, 4'h1, 4'h8, 7'b0000_0_1_0};
        tbl[16] = '{3'd7, 4'h6, 4'h6, 7'b0001_0_0_0};
        tbl[17] = '{3'd7, 4'h6, 4'h7, 7'b0000_0_1_0};

        repeat (3) @(negedge clk);
        check("rst_status", 64'({busy_a, done_a, pass_a}), 64'd0);
        check("rst_counts", 64'({err_a, vec_a}), 64'd0);
        check("rst_stim", 64'({op_a, c_a, x_a, y_a}), 64'd0);
        check("rst_fail", 64'({fop_a, fx_a, fy_a, fgot_a}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            t_op = tbl[i].op;
            t_x  = tbl[i].x;
            t_y  = tbl[i].y;
            #1;
            check($sformatf("ref_vec%0d", i),
                  64'({t_s, t_c, t_z, t_of}), 64'(tbl[i].exp));
        end

        @(negedge clk);
        sweep_a(-1, cyc);
        check("s1_cycles", 64'(cyc), 64'd1536);
        check("s1_pass", 64'({done_a, pass_a}), 64'b11);
        check("s1_err", 64'(err_a), 64'd0);
        check("s1_vec", 64'(vec_a), 64'd512);
        check("s1_inc", 64'(c_a), 64'd0);

        sweep_a(50, cyc);
        check("poke_cycles", 64'(cyc), 64'd1536);
        check("poke_vec", 64'(vec_a), 64'd512);
        check("poke_pass", 64'(pass_a), 64'd1);

        fault = 2'd1;
        sweep_a(-1, cyc);
        check("c0_cycles", 64'(cyc), 64'd1536);
        check("c0_err", 64'(err_a), 64'd256);
        check("c0_pass", 64'({done_a, pass_a}), 64'b10);
        check("c0_fail_stim", 64'({fop_a, fx_a, fy_a}),
              64'({3'd0, 4'h1, 4'hF}));
        check("c0_fail_got", 64'(fgot_a), 64'(7'b0000_0_1_0));

        fault = 2'd2;
        sweep_a(-1, cyc);
        check("z0_err", 64'(err_a), 64'd32);
        check("z0_fail_stim", 64'({fop_a, fx_a, fy_a}), 64'd0);
        check("z0_fail_got", 64'(fgot_a), 64'd0);
        fault = 2'd0;

        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (99) @(negedge clk);
        check("mid_vec", 64'(vec_a), 64'd33);
        check("mid_busy", 64'(busy_a), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_status", 64'({busy_a, done_a, pass_a}), 64'd0);
        check("mid_rst_counts", 64'({err_a, vec_a}), 64'd0);
        check("mid_rst_fail", 64'({fop_a, fx_a, fy_a, fgot_a}), 64'd0);
        sweep_a(-1, cyc);
        check("re_cycles", 64'(cyc), 64'd1536);
        check("re_result", 64'({pass_a, err_a, vec_a}),
              64'({1'b1, 16'd0, 16'd512}));

        start_n = 1'b1;
        @(negedge clk);
        start_n = 1'b0;
        check("none_done", 64'({busy_n, done_n, pass_n}), 64'b011);
        check("none_vec", 64'(vec_n), 64'd0);

        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("e4_first_op", 64'(busy_b), 64'd1);
        cyc = 0;
        while (!done_b && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("e4_cycles", 64'(cyc), 64'd3072);
        check("e4_result", 64'({pass_b, err_b, vec_b}),
              64'({1'b1, 16'd0, 16'd1024}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_selftest.md
# alu_selftest

On-chip stimulus generator and checker for the combinational `alu`. It drives the ALU's `op`/`in_c`/`in_x`/`in_y` inputs and samples its `out_s`/`out_c`/`zero`/`overflow` outputs. On `start`, it sweeps every operand pair for every enabled opcode and compares each response against an internal reference model. It counts mismatches and captures the first failing vector. The block sits beside the ALU on the board build and replaces the simulation bench for silicon and FPGA bring-up.

## Interface
Parameters:
- `WIDTH`, 4: ALU operand/result width.
- `OP_MASK`, 8'hFF: bit k set means opcode k is exercised.
- `SETTLE`, 1: number of wait cycles between driving a vector and checking it (≥1).

Ports (one clock, `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `op`  out  3  opcode to ALU.
- `in_c`  out  1  carry-in to ALU; constant 0.
- `in_x`  out  WIDTH  operand x to ALU.
- `in_y`  out  WIDTH  operand y to ALU.
- `out_s`  in  WIDTH  ALU result.
- `out_c`  in  1  ALU carry.
- `zero`  in  1  ALU zero flag.
- `overflow`  in  1  ALU signed overflow.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; held until the next `start` or reset.
- `pass`  out  1  valid with `done`; 1 iff `err_count`==0.
- `err_count`  out  16  mismatch count, saturating at 16'hFFFF.
- `vec_count`  out  16  number of vectors checked.
- `fail_op`, `fail_x`, `fail_y`  out  3/WIDTH/WIDTH  first failing stimulus.
- `fail_got`  out  WIDTH+3  first failing response, ordered {out_s, out_c, zero, overflow}.

## Operation
- Reference model, with s = result and flags per opcode:
  - 000 add: s = x+y; c = carry-out; of = signed overflow.
  - 001 sub: s = x+~y+1; c = raw carry-out of that sum (1 iff x≥y unsigned); of = signed overflow.
  - 010 not ~x; 011 and; 100 or; 101 xor; c = of = 0.
  - 110 signed less-than: s = {0…,x<y}. 111 equal: s = {0…,x==y}. c = of = 0.
  - zero = (s==0) for all opcodes.
- Sweep order: op outer (ascending, skipping opcodes whose mask bit is clear), x middle, y inner, each 0 to 2^WIDTH−1.
- FSM states:
  - IDLE: on `start`, clear counters and fail capture, load the first enabled op, go to DRIVE. If OP_MASK==0, go straight to DONE.
  - DRIVE: register op/x/y onto the ALU inputs (1 cycle), then go to WAIT.
  - WAIT: stay SETTLE cycles, then go to CHECK.
  - CHECK: compare the four outputs against the model (1 cycle). Increment `vec_count`. On mismatch, increment `err_count`; if it is the first mismatch, latch the `fail_*` outputs. Advance the indices and go to DRIVE, or go to DONE after the last vector.
  - DONE: `done`=1. `start` restarts the sweep as from IDLE.
- `start` is ignored while `busy`=1.

## Timing
- Reset values: all outputs 0, including `pass` and the `fail_*` outputs. State is IDLE.
- Each vector takes 2+SETTLE cycles. Total sweep = popcount(OP_MASK)·2^(2·WIDTH)·(2+SETTLE) cycles from the `start` cycle until `done` rises.
- `busy` rises the cycle after `start` is accepted and falls the same cycle `done` rises.
- ALU inputs hold steady from DRIVE through CHECK.
- The model compares against the registered stimulus, not the next-pointer values.
- `rst` mid-sweep: return to IDLE next cycle with all outputs at their reset values.
- Counter wrap: the index increment carries y → x → op. The carry out of the last enabled op ends the sweep.

## Structure
- Shared package `alu_pkg`: opcode constants (OP_ADD…OP_EQ) and the response-packing order for `fail_got`.
- Sub-module `alu_ref_model`: combinational, parameterised by WIDTH, maps (op, x, y) to the expected {s, c, zero, of}. The bench reuses it for scoreboarding.

## Test plan
- Correct ALU, WIDTH=4, OP_MASK=8'h03, SETTLE=1, pulse `start`: `done` after 1536 cycles, `pass`=1, `err_count`=0, `vec_count`=512.
- `out_c` forced to 0, same config: `err_count`=256 (120 add + 136 sub); first fail is op=000, x=0001, y=1111, `fail_got`={0000,0,1,0}.
- `zero` forced to 0, OP_MASK=8'h03: `err_count`=32; first fail is op=000, x=0000, y=0000.
- OP_MASK=8'h00, `start`: `done`=1 the next cycle, `pass`=1, `vec_count`=0.
- Reset mid-sweep: `start`, then `rst` at cycle 100. Next cycle `busy`=0, `done`=0, and all counters are 0. A fresh `start` completes normally.
- `start` pulsed at cycle 50 while `busy`: ignored; `done` timing and `vec_count` are unchanged from the first scenario.
